// File: rtl/bp_be_hardfloat_pkg.sv
// Shared hardfloat types: recoded dp layout, NaN/const encodings
// and the divide/sqrt controller state enum.
package bp_be_hardfloat_pkg;

  localparam int dp_rec_width_gp = 65;
  localparam int fflags_width_gp = 5;

  // eflags bit positions: {NV,DZ,OF,UF,NX}
  localparam int eflag_nv_gp = 4;
  localparam int eflag_dz_gp = 3;

  typedef struct packed {
    logic        sign;
    logic [11:0] exp;
    logic [51:0] fract;
  } bp_hardfloat_rec_dp_s;

  localparam bp_hardfloat_rec_dp_s dp_canonical_rec =
    {1'b0, 12'he00, 52'h8000000000000};
  localparam bp_hardfloat_rec_dp_s dp_rec_1_0 =
    {1'b0, 12'h800, 52'h0};
  localparam bp_hardfloat_rec_dp_s dp_rec_0_0 =
    {1'b0, 12'h000, 52'h0};

  typedef enum logic [2:0] {
    e_idle,
    e_issue,
    e_busy,
    e_drain,
    e_done
  } bp_be_fdivsqrt_state_e;

  // Invalid results collapse to the canonical NaN.
  function automatic logic [dp_rec_width_gp-1:0] fix_result
    (input logic [dp_rec_width_gp-1:0] data,
     input logic [fflags_width_gp-1:0] eflags);
    return eflags[eflag_nv_gp] ? dp_canonical_rec : data;
  endfunction

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous active-high reset to zero.
// Ports: clk_i, reset_i, en_i, data_i -> data_o.
module bsg_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] r_data;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_data <= '0;
    else if (en_i)
      r_data <= data_i;
  end

  assign data_o = r_data;

endmodule

// File: rtl/bp_be_fdivsqrt_ctrl.sv
// Control FSM around the shared external divide/sqrt datapath:
// request capture, issue, result/flag fixup, kill drain, watchdog.
import bp_be_hardfloat_pkg::*;

module bp_be_fdivsqrt_ctrl #(
  parameter int latency_max_p = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,

  input  logic        v_i,
  output logic        ready_o,
  input  logic        sqrt_i,
  input  logic        sp_i,
  input  logic [64:0] a_i,
  input  logic [64:0] b_i,
  input  logic [2:0]  rm_i,
  input  logic        kill_i,

  output logic        ds_v_o,
  input  logic        ds_ready_i,
  output logic        ds_sqrt_o,
  output logic        ds_sp_o,
  output logic [64:0] ds_a_o,
  output logic [64:0] ds_b_o,
  output logic [2:0]  ds_rm_o,
  input  logic        ds_v_i,
  input  logic [64:0] ds_data_i,
  input  logic [4:0]  ds_eflags_i,

  output logic        v_o,
  output logic [64:0] data_o,
  output logic [4:0]  fflags_o,
  input  logic        yumi_i,
  output logic        timeout_o
);

  localparam int cnt_w_lp = $clog2(latency_max_p+1);
  localparam logic [cnt_w_lp-1:0] cnt_sat_lp =
    cnt_w_lp'(latency_max_p);
  localparam logic [cnt_w_lp-1:0] cnt_fire_lp =
    cnt_w_lp'(latency_max_p-1);

  bp_be_fdivsqrt_state_e r_state;
  logic [cnt_w_lp-1:0]   r_cnt;

  logic w_accept;
  logic w_inflight;
  logic w_fire;
  logic w_capture;

  assign w_accept   = (r_state == e_idle) & v_i & ~kill_i;
  assign w_inflight = (r_state == e_busy)
                    | (r_state == e_drain);
  assign w_fire     = w_inflight & (r_cnt == cnt_fire_lp);
  assign w_capture  = (r_state == e_busy) & ds_v_i
                    & ~kill_i & ~w_fire;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_idle;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        e_idle:
          if (w_accept) r_state <= e_issue;
        e_issue:
          // a kill racing the handshake still owns the datapath
          if (ds_ready_i)
            r_state <= kill_i ? e_drain : e_busy;
          else if (kill_i)
            r_state <= e_idle;
        e_busy:
          if (w_fire)
            r_state <= e_idle;
          else if (kill_i)
            r_state <= ds_v_i ? e_idle : e_drain;
          else if (ds_v_i)
            r_state <= e_done;
        e_drain:
          if (w_fire | ds_v_i) r_state <= e_idle;
        e_done:
          if (yumi_i | kill_i) r_state <= e_idle;
        default:
          r_state <= e_idle;
      endcase

      // zero outside flight, so busy/drain always start at 0
      if (w_inflight)
        r_cnt <= (r_cnt == cnt_sat_lp) ? r_cnt
                                       : r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  logic [134:0] w_req_d;
  logic [134:0] w_req_q;

  assign w_req_d = {sqrt_i, sp_i, rm_i, a_i, b_i};

  bsg_dff_reset_en #(.width_p(135)) u_req (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (w_accept),
    .data_i  (w_req_d),
    .data_o  (w_req_q)
  );

  assign ds_sqrt_o = w_req_q[134];
  assign ds_sp_o   = w_req_q[133];
  assign ds_rm_o   = w_req_q[132:130];
  assign ds_a_o    = w_req_q[129:65];
  assign ds_b_o    = w_req_q[64:0];

  logic [4:0]  w_res_flags;
  logic [69:0] w_res_d;
  logic [69:0] w_res_q;

  // sqrt cannot divide by zero
  always_comb begin
    w_res_flags = ds_eflags_i;
    w_res_flags[eflag_dz_gp] =
      ds_eflags_i[eflag_dz_gp] & ~ds_sqrt_o;
  end

  assign w_res_d = {fix_result(ds_data_i, ds_eflags_i),
                    w_res_flags};

  bsg_dff_reset_en #(.width_p(70)) u_res (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (w_capture),
    .data_i  (w_res_d),
    .data_o  (w_res_q)
  );

  assign data_o    = w_res_q[69:5];
  assign fflags_o  = w_res_q[4:0];

  assign ready_o   = (r_state == e_idle);
  assign ds_v_o    = (r_state == e_issue);
  assign v_o       = (r_state == e_done);
  assign timeout_o = w_fire;

endmodule
